// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter_pkg
// Description : Shared types and constants for the unified fetch/data arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_BUS = 2'd1,
        I_BUS = 2'd2
    } arb_state_t;

    localparam int         TIMEOUT_DEFAULT = 64;
    localparam int         CNT_W_DEFAULT   = 32;
    localparam logic [3:0] BUS_WE_READ     = 4'b0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones, async active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Serialises IF fetches and MEM loads/stores onto one req/ack bus.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic [31:0]      if_rdata,
    output logic             if_stall,
    input  logic             mem_rd,
    input  logic [3:0]       mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic [31:0]      mem_rdata,
    output logic             mem_stall,
    output logic             bus_req,
    output logic [3:0]       bus_we,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    input  logic             bus_ack,
    input  logic [31:0]      bus_rdata,
    output logic             bus_err,
    output logic [CNT_W-1:0] perf_istall,
    output logic [CNT_W-1:0] perf_dstall
);

    localparam int               C_WAIT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(TIMEOUT - 1);

    arb_state_t          state_q,     state_d;
    logic                bus_req_q,   bus_req_d;
    logic [3:0]          bus_we_q,    bus_we_d;
    logic [31:0]         bus_addr_q,  bus_addr_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic [31:0]         cap_addr_q,  cap_addr_d;
    logic [C_WAIT_W-1:0] wait_q,      wait_d;
    logic                i_hold_q,    i_hold_d;
    logic                d_hold_q,    d_hold_d;
    logic [31:0]         ia_q,        ia_d;
    logic [31:0]         da_q,        da_d;
    logic [31:0]         if_rdata_q,  if_rdata_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;
    logic                bus_err_q,   bus_err_d;

    logic        w_dreq;
    logic        w_i_done;
    logic        w_d_done;
    logic        w_if_stall;
    logic        w_mem_stall;
    logic        w_advance;
    logic        w_finish;
    logic [31:0] w_rdata_in;

    assign w_dreq      = mem_rd | (|mem_we);
    assign w_i_done    = i_hold_q & (if_addr == ia_q);
    assign w_d_done    = d_hold_q & (mem_addr == da_q);
    assign w_if_stall  = if_req & ~w_i_done;
    assign w_mem_stall = w_dreq & ~w_d_done;
    assign w_advance   = ~w_if_stall & ~w_mem_stall;

    // An ack on the very cycle the wait limit is reached still counts as a
    // real completion; only an unanswered limit is an abort with zero data.
    assign w_finish   = (state_q != IDLE) && (bus_ack || (wait_q == C_WAIT_LAST));
    assign w_rdata_in = bus_ack ? bus_rdata : 32'h0;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        cap_addr_d  = cap_addr_q;
        wait_d      = wait_q;
        i_hold_d    = i_hold_q;
        d_hold_d    = d_hold_q;
        ia_d        = ia_q;
        da_d        = da_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = bus_err_q;

        // Holds clear on advance; a hold set below on the same edge wins.
        if (w_advance) begin
            i_hold_d = 1'b0;
            d_hold_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (w_mem_stall) begin
                    state_d     = D_BUS;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = word_align(mem_addr);
                    bus_wdata_d = mem_wdata;
                    cap_addr_d  = mem_addr;
                    wait_d      = '0;
                end else if (w_if_stall) begin
                    state_d    = I_BUS;
                    bus_req_d  = 1'b1;
                    bus_we_d   = BUS_WE_READ;
                    bus_addr_d = word_align(if_addr);
                    cap_addr_d = if_addr;
                    wait_d     = '0;
                end
            end

            D_BUS, I_BUS: begin
                if (w_finish) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (!bus_ack) begin
                        bus_err_d = 1'b1;
                    end
                    // The hold is keyed to the address captured at issue time,
                    // so a request that moved on meanwhile stalls again.
                    if (state_q == D_BUS) begin
                        d_hold_d = 1'b1;
                        da_d     = cap_addr_q;
                        if (bus_we_q == BUS_WE_READ) begin
                            mem_rdata_d = w_rdata_in;
                        end
                    end else begin
                        i_hold_d   = 1'b1;
                        ia_d       = cap_addr_q;
                        if_rdata_d = w_rdata_in;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= BUS_WE_READ;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            cap_addr_q  <= '0;
            wait_q      <= '0;
            i_hold_q    <= 1'b0;
            d_hold_q    <= 1'b0;
            ia_q        <= '0;
            da_q        <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            cap_addr_q  <= cap_addr_d;
            wait_q      <= wait_d;
            i_hold_q    <= i_hold_d;
            d_hold_q    <= d_hold_d;
            ia_q        <= ia_d;
            da_q        <= da_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_istall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_if_stall),
        .count (perf_istall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_dstall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_mem_stall),
        .count (perf_dstall)
    );

    assign if_stall  = w_if_stall;
    assign mem_stall = w_mem_stall;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one external memory port between the IF-stage fetch and the MEM/WB-stage data access (load/store).
- Sits between the pipeline and the memory. Its stall outputs drive the hazard unit's ICacheMiss/DCacheMiss inputs, which are currently tied low.
- Serialises accesses with a req/ack handshake of variable latency.
- Keeps per-requester stall-cycle performance counters and a sticky bus-timeout flag.

Parameters:
- TIMEOUT, 64, cycles in a bus state without bus_ack before the access is aborted.
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request this cycle
- if_addr  in  32  fetch address (PCF)
- if_rdata  out  32  fetched word
- if_stall  out  1  to ICacheMiss
- mem_rd  in  1  load request
- mem_we  in  4  store byte enables
- mem_addr  in  32  data address (AluOutM)
- mem_wdata  in  32  store data (StoreDataM)
- mem_rdata  out  32  loaded word
- mem_stall  out  1  to DCacheMiss
- bus_req  out  1  external request, held until ack
- bus_we  out  4  external byte enables, 0 = read
- bus_addr  out  32  external address, word-aligned ([1:0] forced to 0)
- bus_wdata  out  32  external write data
- bus_ack  in  1  single-cycle completion
- bus_rdata  in  32  read data, valid with bus_ack
- bus_err  out  1  sticky timeout flag
- perf_istall  out  CNT_W  cycles with if_stall=1
- perf_dstall  out  CNT_W  cycles with mem_stall=1

Behaviour:
- Reset, asynchronous, including mid-transaction:
  - state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - Both hold flags=0, held addresses=0, if_rdata=mem_rdata=0.
  - bus_err=0, counters=0.
- Data request active: dreq = mem_rd | (|mem_we).
- Hold flags:
  - i_hold and d_hold are each set on completion of that requester's access, together with a latched address ia_q/da_q.
  - i_done = i_hold & (if_addr==ia_q); d_done = d_hold & (mem_addr==da_q).
- Stall outputs are combinational:
  - if_stall = if_req & ~i_done.
  - mem_stall = dreq & ~d_done.
- Advance: the pipeline advances on any edge where if_stall=0 and mem_stall=0. Both holds clear on that edge, unless the same edge also sets a hold.
- FSM states: IDLE, D_BUS, I_BUS.
  - IDLE: if mem_stall, go to D_BUS and capture mem_addr/mem_we/mem_wdata into the bus registers. Else if if_stall, go to I_BUS with bus_we=0. Data has priority (older instruction).
  - D_BUS / I_BUS: bus_req=1, bus signals stable.
    - On bus_ack: latch bus_rdata into mem_rdata (loads only; stores leave mem_rdata unchanged) or into if_rdata. Set the matching hold and latch its address. Drop bus_req. Return to IDLE.
- Latency:
  - Request presented in cycle 0 (IDLE); bus_req high in cycle 1.
  - With ack in cycle 1 + k, the stall falls in cycle 2 + k, so the minimum stall is 2 cycles.
  - Back-to-back: a data miss, then a fetch miss in the same pipeline cycle, serialise. The data hold persists until the fetch also completes.
- Timeout:
  - Wait counter resets on entry to a bus state.
  - When the counter reaches TIMEOUT-1 with no ack: abort, drop bus_req, set bus_err (sticky until rst), deliver rdata=0, set the hold as if acked, return to IDLE.
- Withdrawn or changed request while in a bus state: the transaction still completes. The hold is set against the captured address, so a different new address stalls again.
- bus_ack in IDLE is ignored.
- Counters: increment each cycle their stall is high, saturating at all-ones.
- perf_* and bus_err are registered; the stalls are combinational.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, D_BUS=2'd1, I_BUS=2'd2);
  - the TIMEOUT default;
  - a BUS_WE_READ=4'b0 constant.
- One sub-module: sat_counter (CNT_W, inc, async rst), instantiated twice for perf_istall and perf_dstall.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, ack 3 cycles after bus_req with bus_rdata=0x00000013 -> if_stall high 5 cycles, bus_addr=0x100, bus_we=0, if_rdata=0x13, perf_istall=5.
- Simultaneous: if_req@0x104, mem_rd@0x2000, ack=1 immediately each time -> data is served first (bus_addr 0x2000 then 0x104). mem_stall falls first, while if_stall stays high 2 more cycles. Both holds clear on the common advance edge.
- Store: mem_we=4'b0011, mem_addr=0x2006, mem_wdata=0xABCD1234 -> bus_we=4'b0011, bus_addr=0x2004, mem_rdata unchanged.
- Timeout with TIMEOUT=8: ack never arrives -> bus_req falls after 8 cycles, bus_err=1 and stays 1, mem_rdata=0, mem_stall falls.
- Reset mid-transaction: assert rst during D_BUS -> bus_req=0, both stalls reflect fresh requests, counters=0, bus_err=0. After release with mem_rd still high, the access restarts from IDLE.
- Address change during I_BUS: if_addr changes 0x100->0x200 before ack -> the 0x100 fetch completes, if_stall stays high, and a second fetch of 0x200 is issued.
